// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner, credit-limited imem requests, in-order fetch queue.
// Optional build macro: FETCH_MISALIGN_CHECK_EN (sticky misaligned-redirect fault).
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        fetch_fault_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   inst_d [DEPTH];
  logic [31:0]   ipc_q  [DEPTH];
  logic [31:0]   ipc_d  [DEPTH];
  logic [31:0]   pf_q   [DEPTH];
  logic [31:0]   pf_d   [DEPTH];
  logic [PW-1:0] qhd_q, qhd_d;
  logic [PW-1:0] qtl_q, qtl_d;
  logic [PW-1:0] pfhd_q, pfhd_d;
  logic [PW-1:0] pftl_q, pftl_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] infl_q, infl_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW:0]   credit;
  logic          fire, rsp, discard, push, pop;
  logic          fault;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;

  // Fault is sticky: any misaligned redirect latches it until reset.
  always_comb begin
    fault_d = fault_q | (redirect & (redirect_pc[1:0] != 2'b00));
  end

  // Fault flag register.
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  assign fault = fault_q;
`else
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];
  assign fault      = 1'b0;
`endif

  assign fetch_fault_o = fault;

  // Issue only while queue slots plus outstanding requests leave room.
  always_comb begin
    credit    = {1'b0, occ_q} + {1'b0, infl_q};
    imem_req  = ~rst & ~redirect & ~fault & (credit < {1'b0, DEPTH_C});
    imem_addr = pc_q;
  end

  assign valid_o = (occ_q != '0);
  assign inst_o  = valid_o ? inst_q[qhd_q] : NOP;
  assign pc_o    = valid_o ? ipc_q[qhd_q]  : 32'h0;

  // Next-state for PC, counters, queue and PC FIFO; redirect wins.
  always_comb begin
    fire    = imem_req & imem_gnt;
    rsp     = imem_rvalid & (infl_q != '0);
    discard = rsp & (drop_q != '0);
    push    = rsp & ~discard & ~redirect;
    pop     = valid_o & ~stall & ~redirect;

    pc_d   = pc_q;
    inst_d = inst_q;
    ipc_d  = ipc_q;
    pf_d   = pf_q;
    qhd_d  = qhd_q;
    qtl_d  = qtl_q;
    pfhd_d = pfhd_q;
    pftl_d = pftl_q;
    occ_d  = occ_q;
    infl_d = infl_q;
    drop_d = drop_q;

    if (fire) begin
      pc_d         = pc_q + 32'd4;
      pf_d[pftl_q] = pc_q;
      pftl_d       = ptr_inc(pftl_q);
    end

    if (rsp) begin
      pfhd_d = ptr_inc(pfhd_q);
    end

    if (fire & ~rsp) begin
      infl_d = infl_q + CW'(1);
    end else if (rsp & ~fire) begin
      infl_d = infl_q - CW'(1);
    end

    if (discard) begin
      drop_d = drop_q - CW'(1);
    end

    if (push) begin
      inst_d[qtl_q] = imem_rdata;
      ipc_d[qtl_q]  = pf_q[pfhd_q];
      qtl_d         = ptr_inc(qtl_q);
    end

    if (pop) begin
      qhd_d = ptr_inc(qhd_q);
    end

    if (push & ~pop) begin
      occ_d = occ_q + CW'(1);
    end else if (pop & ~push) begin
      occ_d = occ_q - CW'(1);
    end

    if (redirect) begin
      occ_d  = '0;
      qhd_d  = '0;
      qtl_d  = '0;
      drop_d = infl_d;
      pc_d   = {redirect_pc[31:2], 2'b00};
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      qhd_q  <= '0;
      qtl_q  <= '0;
      pfhd_q <= '0;
      pftl_q <= '0;
      occ_q  <= '0;
      infl_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      qhd_q  <= qhd_d;
      qtl_q  <= qtl_d;
      pfhd_q <= pfhd_d;
      pftl_q <= pftl_d;
      occ_q  <= occ_d;
      infl_q <= infl_d;
      drop_q <= drop_d;
    end
  end

  // Payload storage; validity is carried by the pointers and counters.
  always_ff @(posedge clk) begin
    inst_q <= inst_d;
    ipc_q  <= ipc_d;
    pf_q   <= pf_d;
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: random-latency imem model, epoch-tagged scoreboard
// for the fetch stream, directed reset/stall/redirect/wrap/misalign cases.
`timescale 1ns/1ps
module tb_if_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        fetch_fault_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .valid_o(valid_o), .inst_o(inst_o), .pc_o(pc_o),
    .fetch_fault_o(fetch_fault_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Memory model state: outstanding requests in order, with ready cycle
  // and the redirect epoch they were issued in.
  logic [31:0] pa[$];
  int          pr[$];
  int          pe[$];
  int          cyc = 0;
  int          last_ready = 0;
  int          lat = 1;
  bit          gnt_rand = 0;
  bit          lat_rand = 0;
  bit          gnt_en = 1;

  // Reference stream: every word granted since the last redirect/reset
  // must come out in grant order, addresses counting up by 4.
  logic [31:0] exq_pc[$];
  logic [31:0] exq_in[$];
  logic [31:0] nxt_pc = RESET_PC;
  int          epoch = 0;
  bit          fault_m = 0;
  bit          prev_rst = 0;
  bit          prev_redir = 0;

  // Memory drives grant and in-order responses shortly after each edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    imem_gnt    = gnt_en && (gnt_rand ? (($urandom % 4) != 0) : 1'b1);
    imem_rvalid = (pr.size() > 0) && (pr[0] <= cyc);
    imem_rdata  = imem_rvalid ? mem_word(pa[0]) : $urandom;
  end

  // Monitor: checks against the reference, then advances memory/model.
  always @(negedge clk) begin
    int live;
    int l;
    int r;
    logic [31:0] ep;
    logic [31:0] ei;
    if (rst) begin
      chk1("req_in_reset", imem_req, 1'b0);
      pa.delete(); pr.delete(); pe.delete();
      last_ready = 0;
      exq_pc.delete(); exq_in.delete();
      nxt_pc  = RESET_PC;
      epoch   = epoch + 1;
      fault_m = 0;
    end else begin
      live = 0;
      foreach (pe[i]) if (pe[i] == epoch) live++;
      if (prev_rst) begin
        chk1("reset_valid", valid_o, 1'b0);
        chk("reset_inst", inst_o, NOP);
        chk("reset_pc", pc_o, 32'h0);
        chk1("reset_fault", fetch_fault_o, 1'b0);
      end
      if (prev_redir) chk1("valid_after_redirect", valid_o, 1'b0);
      chk1("credit_req", imem_req,
           !redirect && !fault_m &&
           ((exq_pc.size() - live + pa.size()) < DEPTH));
      chk1("fault_flag", fetch_fault_o, fault_m);
      if (!valid_o) begin
        chk("empty_inst", inst_o, NOP);
        chk("empty_pc", pc_o, 32'h0);
      end else if (!stall && !redirect) begin
        if (exq_pc.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got pc %h expected none", pc_o);
        end else begin
          ep = exq_pc.pop_front();
          ei = exq_in.pop_front();
          chk("pop_pc", pc_o, ep);
          chk("pop_inst", inst_o, ei);
        end
      end
      if (imem_rvalid && pa.size() > 0) begin
        void'(pa.pop_front());
        void'(pr.pop_front());
        void'(pe.pop_front());
      end
      if (imem_req && imem_gnt) begin
        chk("req_addr", imem_addr, nxt_pc);
        exq_pc.push_back(nxt_pc);
        exq_in.push_back(mem_word(nxt_pc));
        l = lat_rand ? int'($urandom_range(1, 3)) : lat;
        r = cyc + l;
        if (r <= last_ready) r = last_ready + 1;
        last_ready = r;
        pa.push_back(imem_addr);
        pr.push_back(r);
        pe.push_back(epoch);
        nxt_pc = nxt_pc + 32'd4;
      end
      if (redirect) begin
        exq_pc.delete(); exq_in.delete();
        nxt_pc = {redirect_pc[31:2], 2'b00};
        epoch  = epoch + 1;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) fault_m = 1;
`endif
      end
    end
    prev_rst   = rst;
    prev_redir = redirect && !rst;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_head(input logic [31:0] exp, input string name);
    bit seen;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (valid_o) begin
        seen = 1;
        chk(name, pc_o, exp);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no valid_o in 40 cycles, expected pc %h", name, exp);
    end
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] head;
    bit found;

    // Reset, then first fetch latency: valid in cycle 2 with pc 0.
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk); chk1("first_valid_c0", valid_o, 1'b0);
    @(negedge clk); chk1("first_valid_c1", valid_o, 1'b0);
    @(negedge clk);
    chk1("first_valid_c2", valid_o, 1'b1);
    chk("first_pc", pc_o, RESET_PC);
    chk("first_inst", inst_o, mem_word(RESET_PC));
    tick();

    // Stall for 5 cycles with a valid head.
    for (int k = 0; k < 20 && !valid_o; k++) tick();
    stall = 1'b1;
    head  = pc_o;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_head", pc_o, head);
      if (i == 4) chk1("stall_req_off", imem_req, 1'b0);
      tick();
    end
    stall = 1'b0;
    repeat (4) tick();

    // Redirect with two requests in flight and 3-cycle latency.
    lat   = 3;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      if (pa.size() == 2 && !imem_rvalid) found = 1;
    end
    chk1("redir_inflight_setup", found, 1'b1);
    do_redirect(32'h0000_0100);
    wait_head(32'h0000_0100, "redir_target");
    tick();

    // Redirect in a cycle carrying both a grant and a response.
    lat   = 1;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      if (imem_rvalid && imem_gnt) found = 1;
    end
    chk1("redir_rsp_setup", found, 1'b1);
    do_redirect(32'h0000_0200);
    wait_head(32'h0000_0200, "redir_rsp_target");
    tick();

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFFC);
    wait_head(32'hFFFF_FFFC, "wrap_last");
    wait_head(32'h0000_0000, "wrap_zero");
    tick();

    // Misaligned redirect.
    do_redirect(32'h0000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk1("misalign_fault", fetch_fault_o, 1'b1);
      chk1("misalign_no_req", imem_req, 1'b0);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_head(RESET_PC, "misalign_after_reset");
`else
    wait_head(32'h0000_0100, "misalign_masked");
    chk1("misalign_no_fault", fetch_fault_o, 1'b0);
`endif
    tick();

    // Random traffic: stalls, redirects, grant gaps, latency 1..3, reset.
    gnt_rand = 1;
    lat_rand = 1;
    for (int k = 0; k < 600; k++) begin
      stall       = ($urandom % 4) == 0;
      redirect    = ($urandom % 25) == 0;
`ifdef FETCH_MISALIGN_CHECK_EN
      redirect_pc = $urandom & 32'hFFFF_FFFC;
`else
      redirect_pc = $urandom;
`endif
      rst = (k == 300);
      tick();
    end
    redirect = 1'b0;
    stall    = 1'b0;
    rst      = 1'b0;
    gnt_en   = 0;
    repeat (40) tick();
    @(negedge clk);
    chk("drain_expected_empty", 32'(exq_pc.size()), 32'h0);
    chk("drain_mem_empty", 32'(pa.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
